// File: rtl/load_store_unit_if.sv
// Request and data-bus bundle for the load/store unit.
// The unit uses the slave modport; execute and the memory model use the master modport.
interface load_store_unit_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_load;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd;

  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  logic        o_rf_write_enable;
  logic [4:0]  o_rf_write_address;
  logic [31:0] o_rf_write_data;
  logic        o_fault;
  logic        o_store_done;

  modport slave (
    input  i_valid, i_is_load, i_is_store, i_funct3, i_addr, i_store_data, i_rd,
    input  i_mem_ack, i_mem_rdata,
    output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    output o_rf_write_enable, o_rf_write_address, o_rf_write_data, o_fault, o_store_done
  );

  modport master (
    output i_valid, i_is_load, i_is_store, i_funct3, i_addr, i_store_data, i_rd,
    output i_mem_ack, i_mem_rdata,
    input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    input  o_rf_write_enable, o_rf_write_address, o_rf_write_data, o_fault, o_store_done
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per transaction over a valid/ack bus,
// with load alignment/extension, register file writeback and fault reporting.
module load_store_unit (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] storeData_q, storeData_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        isLoad_q, isLoad_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wbData_q, wbData_d;
  logic        storeDone_q, storeDone_d;

  logic        typeOk, funct3Ok, misaligned, requestBad;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadResult;
  logic [31:0] laneWdata;
  logic [3:0]  laneWstrb;
  logic        reqActive;

  // Legality of the incoming request, evaluated on the raw inputs in IDLE
  always_comb begin
    typeOk     = bus.i_is_load ^ bus.i_is_store;
    funct3Ok   = 1'b0;
    misaligned = 1'b0;
    case (bus.i_funct3)
      3'b000: funct3Ok = 1'b1;
      3'b001: begin funct3Ok = 1'b1;          misaligned = bus.i_addr[0];      end
      3'b010: begin funct3Ok = 1'b1;          misaligned = |bus.i_addr[1:0];   end
      3'b100: funct3Ok = bus.i_is_load;
      3'b101: begin funct3Ok = bus.i_is_load; misaligned = bus.i_addr[0];      end
      default: funct3Ok = 1'b0;
    endcase
    requestBad = !typeOk || !funct3Ok || misaligned;
  end

  always_comb begin
    laneByte = bus.i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    laneHalf = bus.i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  loadResult = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadResult = {{16{laneHalf[15]}}, laneHalf};
      3'b100:  loadResult = {24'd0, laneByte};
      3'b101:  loadResult = {16'd0, laneHalf};
      default: loadResult = bus.i_mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin laneWdata = {4{storeData_q[7:0]}};  laneWstrb = 4'b0001 << addr_q[1:0]; end
      2'b01: begin laneWdata = {2{storeData_q[15:0]}}; laneWstrb = 4'b0011 << addr_q[1:0]; end
      default: begin laneWdata = storeData_q;          laneWstrb = 4'b1111;               end
    endcase
  end

  // Next-state logic; fields are captured on every acceptance, even faulting ones
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    funct3_d    = funct3_q;
    isLoad_d    = isLoad_q;
    rd_d        = rd_q;
    wbData_d    = wbData_q;
    storeDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          addr_d      = bus.i_addr;
          storeData_d = bus.i_store_data;
          funct3_d    = bus.i_funct3;
          isLoad_d    = bus.i_is_load;
          rd_d        = bus.i_rd;
          state_d     = requestBad ? FAULT : REQ;
        end
      end
      REQ: begin
        if (bus.i_mem_ack) begin
          if (isLoad_q) begin
            wbData_d = loadResult;
            state_d  = WB;
          end else begin
            storeDone_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WB:      state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      storeData_q <= '0;
      funct3_q    <= '0;
      isLoad_q    <= 1'b0;
      rd_q        <= '0;
      wbData_q    <= '0;
      storeDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      funct3_q    <= funct3_d;
      isLoad_q    <= isLoad_d;
      rd_q        <= rd_d;
      wbData_q    <= wbData_d;
      storeDone_q <= storeDone_d;
    end
  end

  // Control outputs are masked by reset so nothing leaks out in the reset cycle
  assign reqActive              = (state_q == REQ) && !reset;
  assign bus.o_ready            = (state_q == IDLE) && !reset;
  assign bus.o_mem_req          = reqActive;
  assign bus.o_mem_we           = reqActive && !isLoad_q;
  assign bus.o_mem_addr         = {addr_q[31:2], 2'b00};
  assign bus.o_mem_wdata        = laneWdata;
  assign bus.o_mem_wstrb        = (reqActive && !isLoad_q) ? laneWstrb : 4'b0000;
  assign bus.o_rf_write_enable  = (state_q == WB) && (rd_q != 5'd0) && !reset;
  assign bus.o_rf_write_address = rd_q;
  assign bus.o_rf_write_data    = wbData_q;
  assign bus.o_fault            = (state_q == FAULT) && !reset;
  assign bus.o_store_done       = storeDone_q && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: loads, stores, faults,
// rd=0 suppression and reset abandoning an outstanding request.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  load_store_unit_if lsuBus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lsuBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request at a negedge and returns at the negedge of cycle T+1
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] rd);
    int waitCycles = 0;
    while (lsuBus.o_ready !== 1'b1 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    assertCount++;
    if (lsuBus.o_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ready_before_request: o_ready=%b required 1", lsuBus.o_ready);
    end
    lsuBus.i_valid      = 1'b1;
    lsuBus.i_is_load    = ld;
    lsuBus.i_is_store   = st;
    lsuBus.i_funct3     = f3;
    lsuBus.i_addr       = addr;
    lsuBus.i_store_data = data;
    lsuBus.i_rd         = rd;
    @(negedge clk);
    lsuBus.i_valid    = 1'b0;
    lsuBus.i_is_load  = 1'b0;
    lsuBus.i_is_store = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    assertCount++;
    if ({lsuBus.o_ready, lsuBus.o_mem_req, lsuBus.o_rf_write_enable, lsuBus.o_fault, lsuBus.o_store_done} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: ready/req/we/fault/done=%b required 00000",
               {lsuBus.o_ready, lsuBus.o_mem_req, lsuBus.o_rf_write_enable, lsuBus.o_fault, lsuBus.o_store_done});
    end
    assertCount++;
    if (lsuBus.o_mem_wstrb !== 4'b0000 || lsuBus.o_mem_addr !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_bus: wstrb=%b addr=%h required 0000/0", lsuBus.o_mem_wstrb, lsuBus.o_mem_addr);
    end
    reset = 1'b0;
    #1;
    assertCount++;
    if (lsuBus.o_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ready_after_reset: o_ready=%b required 1", lsuBus.o_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_load_word();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5);
    assertCount++;
    if (lsuBus.o_mem_req !== 1'b1 || lsuBus.o_mem_addr !== 32'h100 || lsuBus.o_mem_we !== 1'b0 || lsuBus.o_mem_wstrb !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL lw_request: req=%b addr=%h we=%b wstrb=%b required 1/100/0/0000",
               lsuBus.o_mem_req, lsuBus.o_mem_addr, lsuBus.o_mem_we, lsuBus.o_mem_wstrb);
    end
    for (int i = 0; i < 2; i++) begin
      lsuBus.i_mem_rdata = 32'h1111_1111;
      @(negedge clk);
      assertCount++;
      if (lsuBus.o_mem_req !== 1'b1 || lsuBus.o_rf_write_enable !== 1'b0 || lsuBus.o_ready !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL lw_wait: req=%b we=%b ready=%b required 1/0/0",
                 lsuBus.o_mem_req, lsuBus.o_rf_write_enable, lsuBus.o_ready);
      end
    end
    lsuBus.i_mem_ack   = 1'b1;
    lsuBus.i_mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lsuBus.i_mem_ack   = 1'b0;
    lsuBus.i_mem_rdata = 32'h0;
    assertCount++;
    if (lsuBus.o_rf_write_enable !== 1'b1 || lsuBus.o_rf_write_address !== 5'd5 ||
        lsuBus.o_rf_write_data !== 32'hDEAD_BEEF || lsuBus.o_mem_req !== 1'b0 || lsuBus.o_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL lw_writeback: we=%b rd=%0d data=%h req=%b ready=%b required 1/5/deadbeef/0/0",
               lsuBus.o_rf_write_enable, lsuBus.o_rf_write_address, lsuBus.o_rf_write_data,
               lsuBus.o_mem_req, lsuBus.o_ready);
    end
    @(negedge clk);
    assertCount++;
    if (lsuBus.o_rf_write_enable !== 1'b0 || lsuBus.o_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL lw_after: we=%b ready=%b required 0/1", lsuBus.o_rf_write_enable, lsuBus.o_ready);
    end
  endtask

  task automatic test_load_byte_half();
    logic [2:0]  f3List  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] addrList[4] = '{32'h203, 32'h203, 32'h202, 32'h200};
    logic [31:0] expList [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_3456};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, f3List[i], addrList[i], 32'h0, 5'(7 + i));
      assertCount++;
      if (lsuBus.o_mem_req !== 1'b1 || lsuBus.o_mem_addr !== 32'h200) begin
        failCount++;
        $display("[TB] FAIL load%0d_request: req=%b addr=%h required 1/200", i, lsuBus.o_mem_req, lsuBus.o_mem_addr);
      end
      lsuBus.i_mem_ack   = 1'b1;
      lsuBus.i_mem_rdata = 32'h8012_3456;
      @(negedge clk);
      lsuBus.i_mem_ack   = 1'b0;
      lsuBus.i_mem_rdata = 32'h0;
      assertCount++;
      if (lsuBus.o_rf_write_enable !== 1'b1 || lsuBus.o_rf_write_address !== 5'(7 + i) ||
          lsuBus.o_rf_write_data !== expList[i]) begin
        failCount++;
        $display("[TB] FAIL load%0d_writeback: we=%b rd=%0d data=%h required 1/%0d/%h",
                 i, lsuBus.o_rf_write_enable, lsuBus.o_rf_write_address, lsuBus.o_rf_write_data,
                 7 + i, expList[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3List  [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] addrList[3] = '{32'h301, 32'h302, 32'h304};
    logic [31:0] dataList[3] = '{32'h0000_00A5, 32'h1234_BEEF, 32'h1122_3344};
    logic [31:0] expAddr [3] = '{32'h300, 32'h300, 32'h304};
    logic [31:0] expWdata[3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1122_3344};
    logic [3:0]  expStrb [3] = '{4'b0010, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, f3List[i], addrList[i], dataList[i], 5'd3);
      assertCount++;
      if (lsuBus.o_mem_req !== 1'b1 || lsuBus.o_mem_we !== 1'b1 || lsuBus.o_mem_addr !== expAddr[i] ||
          lsuBus.o_mem_wdata !== expWdata[i] || lsuBus.o_mem_wstrb !== expStrb[i]) begin
        failCount++;
        $display("[TB] FAIL store%0d_request: req=%b we=%b addr=%h wdata=%h wstrb=%b required 1/1/%h/%h/%b",
                 i, lsuBus.o_mem_req, lsuBus.o_mem_we, lsuBus.o_mem_addr, lsuBus.o_mem_wdata,
                 lsuBus.o_mem_wstrb, expAddr[i], expWdata[i], expStrb[i]);
      end
      lsuBus.i_mem_ack = 1'b1;
      @(negedge clk);
      lsuBus.i_mem_ack = 1'b0;
      assertCount++;
      if (lsuBus.o_store_done !== 1'b1 || lsuBus.o_ready !== 1'b1 || lsuBus.o_rf_write_enable !== 1'b0 ||
          lsuBus.o_mem_req !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL store%0d_done: done=%b ready=%b we=%b req=%b required 1/1/0/0",
                 i, lsuBus.o_store_done, lsuBus.o_ready, lsuBus.o_rf_write_enable, lsuBus.o_mem_req);
      end
      @(negedge clk);
      assertCount++;
      if (lsuBus.o_store_done !== 1'b0 || lsuBus.o_rf_write_enable !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL store%0d_pulse: done=%b we=%b required 0/0", i, lsuBus.o_store_done, lsuBus.o_rf_write_enable);
      end
    end
  endtask

  task automatic test_fault();
    logic        ldList  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        stList  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3List  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b000};
    logic [31:0] addrList[5] = '{32'h102, 32'h103, 32'h100, 32'h100, 32'h100};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ldList[i], stList[i], f3List[i], addrList[i], 32'hFFFF_FFFF, 5'd4);
      assertCount++;
      if (lsuBus.o_fault !== 1'b1 || lsuBus.o_mem_req !== 1'b0 || lsuBus.o_ready !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL fault%0d_pulse: fault=%b req=%b ready=%b required 1/0/0",
                 i, lsuBus.o_fault, lsuBus.o_mem_req, lsuBus.o_ready);
      end
      @(negedge clk);
      assertCount++;
      if (lsuBus.o_fault !== 1'b0 || lsuBus.o_mem_req !== 1'b0 || lsuBus.o_ready !== 1'b1 ||
          lsuBus.o_rf_write_enable !== 1'b0 || lsuBus.o_store_done !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL fault%0d_after: fault=%b req=%b ready=%b we=%b done=%b required 0/0/1/0/0",
                 i, lsuBus.o_fault, lsuBus.o_mem_req, lsuBus.o_ready, lsuBus.o_rf_write_enable, lsuBus.o_store_done);
      end
    end
  endtask

  task automatic test_rd_zero();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0110, 32'h0, 5'd0);
    assertCount++;
    if (lsuBus.o_mem_req !== 1'b1 || lsuBus.o_mem_addr !== 32'h110) begin
      failCount++;
      $display("[TB] FAIL rd0_request: req=%b addr=%h required 1/110", lsuBus.o_mem_req, lsuBus.o_mem_addr);
    end
    lsuBus.i_mem_ack   = 1'b1;
    lsuBus.i_mem_rdata = 32'h1234_5678;
    @(negedge clk);
    lsuBus.i_mem_ack   = 1'b0;
    assertCount++;
    if (lsuBus.o_rf_write_enable !== 1'b0 || lsuBus.o_rf_write_address !== 5'd0 || lsuBus.o_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rd0_writeback: we=%b rd=%0d ready=%b required 0/0/0",
               lsuBus.o_rf_write_enable, lsuBus.o_rf_write_address, lsuBus.o_ready);
    end
    @(negedge clk);
    assertCount++;
    if (lsuBus.o_ready !== 1'b1 || lsuBus.o_rf_write_enable !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rd0_after: ready=%b we=%b required 1/0", lsuBus.o_ready, lsuBus.o_rf_write_enable);
    end
  endtask

  task automatic test_reset_abort();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0120, 32'h0, 5'd9);
    reset = 1'b1;
    #1;
    assertCount++;
    if (lsuBus.o_mem_req !== 1'b0 || lsuBus.o_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_in_reset: req=%b ready=%b required 0/0", lsuBus.o_mem_req, lsuBus.o_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    assertCount++;
    if (lsuBus.o_mem_req !== 1'b0 || lsuBus.o_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL abort_after_reset: req=%b ready=%b required 0/1", lsuBus.o_mem_req, lsuBus.o_ready);
    end
    lsuBus.i_mem_ack   = 1'b1;
    lsuBus.i_mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    lsuBus.i_mem_ack   = 1'b0;
    assertCount++;
    if (lsuBus.o_rf_write_enable !== 1'b0 || lsuBus.o_store_done !== 1'b0 || lsuBus.o_ready !== 1'b1 ||
        lsuBus.o_mem_req !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_late_ack: we=%b done=%b ready=%b req=%b required 0/0/1/0",
               lsuBus.o_rf_write_enable, lsuBus.o_store_done, lsuBus.o_ready, lsuBus.o_mem_req);
    end
    @(negedge clk);
    assertCount++;
    if (lsuBus.o_rf_write_enable !== 1'b0 || lsuBus.o_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL abort_settle: we=%b ready=%b required 0/1", lsuBus.o_rf_write_enable, lsuBus.o_ready);
    end
  endtask

  initial begin
    reset               = 1'b1;
    lsuBus.i_valid      = 1'b0;
    lsuBus.i_is_load    = 1'b0;
    lsuBus.i_is_store   = 1'b0;
    lsuBus.i_funct3     = 3'b000;
    lsuBus.i_addr       = 32'h0;
    lsuBus.i_store_data = 32'h0;
    lsuBus.i_rd         = 5'd0;
    lsuBus.i_mem_ack    = 1'b0;
    lsuBus.i_mem_rdata  = 32'h0;
    @(negedge clk);
    test_reset();
    test_load_word();
    test_load_byte_half();
    test_store();
    test_fault();
    test_rd_zero();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the core: accepts one load or store per transaction from execute, runs a valid/ack handshake on the 32-bit data bus, aligns and sign/zero-extends load data, and drives the register file write port (write enable, 5-bit address, 32-bit data) for loads. Stores never write the register file. Misaligned or illegal requests raise a one-cycle fault and never reach the bus.

## Interface
- No parameters; data and address are 32 bits, register index 5 bits.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  request present; sampled only when o_ready=1.
- o_ready  out  1  unit idle and accepting; 0 while reset=1.
- i_is_load / i_is_store  in  1 each  operation type; exactly one must be 1.
- i_funct3  in  3  width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- i_addr  in  32  byte address.
- i_store_data  in  32  store source; low byte/half used for B/H.
- i_rd  in  5  load destination register.
- o_mem_req  out  1  bus request, held until ack.
- o_mem_we  out  1  1 = store.
- o_mem_addr  out  32  {i_addr[31:2],2'b00}.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_wstrb  out  4  byte enables; 0000 for loads.
- i_mem_ack  in  1  completes the request in the cycle it is high with o_mem_req=1.
- i_mem_rdata  in  32  read word, valid with i_mem_ack on loads.
- o_rf_write_enable  out  1  one-cycle register file write strobe.
- o_rf_write_address  out  5  captured i_rd.
- o_rf_write_data  out  32  extended load result.
- o_fault  out  1  one-cycle pulse: misaligned or illegal request.
- o_store_done  out  1  one-cycle pulse on store completion.

## Operation
- States: IDLE, REQ, WB, FAULT. Reset forces IDLE; all outputs 0, except o_ready, which rises the first cycle after reset deasserts.
- IDLE: o_ready=1. On i_valid: capture all request fields. Illegal (both/neither type bit set, funct3 not in table, store with 100/101) or misaligned (H with addr[0]=1, W with addr[1:0]!=00) -> FAULT; else -> REQ.
- FAULT: o_fault=1 for exactly one cycle, then -> IDLE. No bus activity, no RF write.
- REQ: o_mem_req=1 with stable address/we/wdata/wstrb until ack. Load ack: capture i_mem_rdata, -> WB. Store ack: o_store_done=1 in the following cycle, -> IDLE.
- WB: o_rf_write_enable=1 for one cycle with address and data, then -> IDLE. Enable suppressed when rd=0 (address still driven).
- Store lanes: B wdata={4{b}}, wstrb=0001<<addr[1:0]; H wdata={2{h}}, wstrb=0011<<addr[1:0]; W wdata=data, wstrb=1111.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; B/H sign-extend bit 7/15, BU/HU zero-extend.
- i_mem_rdata is ignored outside a load ack in REQ. i_mem_ack is ignored outside REQ.

## Timing
- Request accepted at edge T; o_mem_req high from cycle T+1.
- Load with ack in cycle T+1+k (k≥0 wait cycles): write strobe in cycle T+2+k; o_ready in T+3+k. Minimum load occupancy is 3 cycles.
- Store with ack in cycle T+1+k: o_store_done and o_ready in T+2+k. Minimum store occupancy is 2 cycles.
- Fault: o_fault in T+1, o_ready in T+2.
- No back-to-back acceptance: o_ready=0 in REQ, WB, FAULT.
- Reset in any state: next cycle IDLE. o_mem_req, write strobe and pulses drop. A pending transaction is abandoned, and a late ack is ignored.

## Test plan
- LW addr 0x100, bus returns 0xDEADBEEF after 2 wait cycles, rd=5 -> single write of x5=0xDEADBEEF exactly 4 cycles after ack-free acceptance path (T+4); o_mem_addr=0x100.
- LB/LBU addr 0x203, rdata 0x80123456, ack immediate -> LB writes 0xFFFFFF80, LBU writes 0x00000080; LH addr 0x202 same word -> 0xFFFF8012.
- SB addr 0x301, data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 0010, addr 0x300, we=1; SH addr 0x302 -> wstrb 1100; o_store_done one cycle after ack; no RF write.
- LW addr 0x102 and SH addr 0x103 -> o_fault pulse at T+1, o_mem_req never asserted; funct3=011 -> same fault.
- LW with rd=0 -> bus transaction completes, o_rf_write_enable stays 0.
- Reset asserted while REQ waits for ack, ack arrives the cycle after -> no RF write or store_done, o_ready=1 after reset drops.
